// File: rtl/lbp_stream.sv
// Streaming 3x3 local binary pattern (LBP) engine. It fetches a gray image in raster order and emits one code per interior pixel.
// Define LBP_BORDER_ZERO_EN to also emit the border pixels, with code 0, so that the output frame is full size.
module lbp_stream #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int PIX_W = 8,
    localparam int AW = $clog2(IMG_W * IMG_H)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             gray_req,
    output logic [AW-1:0]    gray_addr,
    input  logic             gray_valid,
    input  logic [PIX_W-1:0] gray_data,
    output logic             lbp_valid,
    input  logic             lbp_ready,
    output logic [AW-1:0]    lbp_addr,
    output logic [7:0]       lbp_data,
    output logic             busy,
    output logic             finish
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);
    localparam logic [AW-1:0] CTR_OFS   = AW'(IMG_W + 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(IMG_W - 1);

    logic [1:0]       state;
    logic [AW-1:0]    fetch_addr;
    logic [RW-1:0]    row;
    logic [CW-1:0]    col;
    logic             fetch_done;

    logic             out_valid;
    logic [AW-1:0]    out_addr;
    logic [7:0]       out_data;
    logic             out_last;

    logic [PIX_W-1:0] lb_top [IMG_W];
    logic [PIX_W-1:0] lb_mid [IMG_W];
    logic [2:0][PIX_W-1:0] win_l;
    logic [2:0][PIX_W-1:0] win_c;

    logic [PIX_W-1:0] n_top;
    logic [PIX_W-1:0] n_mid;
    logic [PIX_W-1:0] centre;
    logic [7:0]       lbp_code;
    logic             centre_ok;
    logic             fetch_makes_result;
    logic             slot_free;
    logic             pix_fire;
    logic             load;
    logic [AW-1:0]    load_addr;
    logic [7:0]       load_data;
    logic             load_last;

`ifdef LBP_BORDER_ZERO_EN
    logic [AW-1:0]    drain_addr;
    logic             drain_fire;
`endif

    // The pixel being fetched is the bottom-right corner of the window around (row-1, col-1).
    assign n_top     = lb_top[col];
    assign n_mid     = lb_mid[col];
    assign centre    = win_c[1];
    assign centre_ok = (row >= RW'(2)) && (col >= CW'(2));

    assign lbp_code = {gray_data >= centre, win_c[0] >= centre, win_l[0] >= centre,
                       n_mid >= centre, win_l[1] >= centre, n_top >= centre,
                       win_c[2] >= centre, win_l[2] >= centre};

`ifdef LBP_BORDER_ZERO_EN
    assign fetch_makes_result = (fetch_addr >= CTR_OFS);
    assign drain_fire = (state == S_FETCH) && fetch_done && !out_last && slot_free;
`else
    assign fetch_makes_result = centre_ok;
`endif

    // Stall a fetch only if its result would overwrite a result that the sink has not yet taken.
    assign slot_free = !out_valid || lbp_ready;
    assign gray_req  = (state == S_FETCH) && !fetch_done && (!fetch_makes_result || slot_free);
    assign pix_fire  = gray_req && gray_valid;

    always_comb begin
        load      = 1'b0;
        load_addr = fetch_addr - CTR_OFS;
        load_data = 8'h00;
        load_last = 1'b0;
        if (pix_fire && fetch_makes_result) begin
            load      = 1'b1;
            load_data = centre_ok ? lbp_code : 8'h00;
`ifndef LBP_BORDER_ZERO_EN
            load_last = (fetch_addr == LAST_ADDR);
`endif
        end
`ifdef LBP_BORDER_ZERO_EN
        if (drain_fire) begin
            load      = 1'b1;
            load_addr = drain_addr;
            load_data = 8'h00;
            load_last = (drain_addr == LAST_ADDR);
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            fetch_addr <= '0;
            row        <= '0;
            col        <= '0;
            fetch_done <= 1'b0;
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_data   <= 8'h00;
            out_last   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_FETCH;
                        fetch_addr <= '0;
                        row        <= '0;
                        col        <= '0;
                        fetch_done <= 1'b0;
                        out_last   <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (out_valid && lbp_ready && out_last) begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (pix_fire) begin
                if (col == LAST_COL) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                if (fetch_addr == LAST_ADDR) begin
                    fetch_done <= 1'b1;
                end else begin
                    fetch_addr <= fetch_addr + AW'(1);
                end
            end

            if (load) begin
                out_valid <= 1'b1;
                out_addr  <= load_addr;
                out_data  <= load_data;
                out_last  <= load_last;
            end else if (lbp_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef LBP_BORDER_ZERO_EN
    // The last IMG_W+1 addresses (the end of the right column plus the bottom row) are all border pixels, so they drain as zeros.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drain_addr <= '0;
        end else if (state == S_IDLE && start) begin
            drain_addr <= AW'(IMG_W * IMG_H - IMG_W - 1);
        end else if (drain_fire) begin
            drain_addr <= drain_addr + AW'(1);
        end
    end
`endif

    // Line buffers and window need no reset; a new frame overwrites them before any result reads them.
    always_ff @(posedge clk) begin
        if (pix_fire) begin
            lb_top[col] <= n_mid;
            lb_mid[col] <= gray_data;
            win_l       <= win_c;
            win_c       <= {n_top, n_mid, gray_data};
        end
    end

    assign gray_addr = fetch_addr;
    assign lbp_valid = out_valid;
    assign lbp_addr  = out_addr;
    assign lbp_data  = out_data;
    assign busy      = (state != S_IDLE);
    assign finish    = (state == S_DONE);

endmodule

// File: doc/lbp_stream.md
LBP_STREAM -- requirements
Module: lbp_stream

Interface
REQ-001 Parameter IMG_W, default 128, image width in pixels, SHALL be >= 3.
REQ-002 Parameter IMG_H, default 128, image height in pixels, SHALL be >= 3.
REQ-003 Parameter PIX_W, default 8, gray pixel width in bits.
REQ-004 Localparam AW = clog2(IMG_W*IMG_H), address width.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle frame start request.
REQ-008 gray_req  output  1  pixel read request.
REQ-009 gray_addr  output  AW  raster address of requested pixel.
REQ-010 gray_valid  input  1  gray_data valid for current request.
REQ-011 gray_data  input  PIX_W  returned pixel value.
REQ-012 lbp_valid  output  1  result valid.
REQ-013 lbp_ready  input  1  sink accepts result.
REQ-014 lbp_addr  output  AW  raster address of result pixel.
REQ-015 lbp_data  output  8  LBP code.
REQ-016 busy  output  1  frame in progress.
REQ-017 finish  output  1  one-cycle end-of-frame pulse.

Function
REQ-018 FSM states IDLE, FETCH, DONE; IDLE->FETCH on start, FETCH->DONE on final result handshake, DONE->IDLE after one cycle.
REQ-019 start SHALL be ignored while busy=1; busy=1 from cycle after accepted start through the DONE cycle.
REQ-020 Each pixel address 0..IMG_W*IMG_H-1 SHALL be requested exactly once, ascending; gray_req and gray_addr held stable until a cycle with gray_valid=1, where gray_data is captured.
REQ-021 Block SHALL hold two IMG_W-deep line buffers plus a 3x3 window; no pixel re-fetch.
REQ-022 Interior pixel (r,c), 1<=r<=IMG_H-2, 1<=c<=IMG_W-2, SHALL produce one result with lbp_addr = r*IMG_W+c.
REQ-023 Bit = 1 when neighbour >= centre (unsigned PIX_W compare); bit0 TL, bit1 T, bit2 TR, bit3 L, bit4 R, bit5 BL, bit6 B, bit7 BR.
REQ-024 lbp_valid SHALL rise the cycle after gray_valid for pixel (r+1,c+1) completes that window.
REQ-025 While lbp_valid=1 and lbp_ready=0, lbp_addr/lbp_data SHALL hold; a result transfers only when both are high.
REQ-026 Single-entry output register; fetch SHALL stall (gray_req=0) when a new result would overwrite an unaccepted one.
REQ-027 With gray_valid and lbp_ready held high, sustained throughput SHALL be one pixel per cycle.
REQ-028 Results SHALL be emitted in ascending lbp_addr order without gaps or duplicates.
REQ-029 finish SHALL pulse for exactly the DONE cycle, after the final result handshake.

Reset
REQ-030 reset low SHALL immediately force IDLE, gray_req=0, gray_addr=0, lbp_valid=0, lbp_addr=0, busy=0, finish=0, counters zero.
REQ-031 Reset mid-frame SHALL abandon the frame; line buffer contents need not be cleared; next start SHALL yield a correct frame.
REQ-032 lbp_data SHALL read 0 after reset until the first result.

Configuration
REQ-033 Macro LBP_BORDER_ZERO_EN defined: every address 0..IMG_W*IMG_H-1 emitted once, ascending; border pixels carry lbp_data=0; address a emitted after pixel a+IMG_W+1 fetched, final IMG_W+1 addresses emitted after the last fetch, one per accepted cycle.
REQ-034 Macro undefined: only interior results emitted, (IMG_W-2)*(IMG_H-2) per frame.

Verification
REQ-035 IMG_W=IMG_H=4, all pixels 10 -> results addr 5,6,9,10 each 8'hFF; one finish pulse.
REQ-036 3x3, centre 200, others 100 -> one result addr 4 data 8'h00; TR changed to 200 -> data 8'h04.
REQ-037 Random gray_valid stalls, lbp_ready low 5 cycles -> lbp_addr/lbp_data stable while low; result stream identical to no-stall run.
REQ-038 reset low mid-frame (after ~50 results) -> all outputs zero same cycle; fresh start yields full correct frame.
REQ-039 128x128 ramp: macro defined -> 16384 results, border data 0; undefined -> 15876 results.
REQ-040 start pulsed while busy -> no restart, address sequence unchanged, single finish.
